// File: rtl/simple_mem_responder.sv
// simple_mem_responder
//   Responder end of the shared single-word memory bus. A request (mem_req and
//   mem_en high, address inside this region) is serviced from an internal word
//   array after LATENCY cycles; the response is held until mem_req drops.
//
//   Optional build macro: SIMPLE_MEM_RESPONDER_DECERR_EN
//     defined   : out-of-region requests get a decode-error response
//                 (mem_data = 32'hDEAD_BEEF, mem_err = 1), no array access
//     undefined : out-of-region requests are ignored, mem_err is tied 0
//
//   Ports
//     clk            in   system clock, rising edge
//     reset          in   synchronous active-high reset
//     mem_addr       in   [31:0] byte address (valid while mem_en=1)
//     mem_req        in   initiator request, held until response consumed
//     mem_en         in   initiator drives address/data
//     mem_rd_wr      in   0=read, 1=write, sampled at accept
//     mem_wr_data    in   [31:0] write data, sampled at accept
//     mem_data_valid out  response valid (read data or write ack)
//     mem_data       out  [31:0] read data, 0 when not valid / for write acks
//     mem_data_oe    out  responder drives mem_data, equals mem_data_valid
//     bus_busy_out   out  responder is servicing a request
//     mem_err        out  decode-error flag
//
//   state | meaning
//   IDLE  | waiting for a request
//   WAIT  | request latched, latency counter running
//   RESP  | response presented until mem_req drops
module simple_mem_responder #(
  parameter int          LATENCY    = 2,
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_req,
  input  logic        mem_en,
  input  logic        mem_rd_wr,
  input  logic [31:0] mem_wr_data,
  output logic        mem_data_valid,
  output logic [31:0] mem_data,
  output logic        mem_data_oe,
  output logic        bus_busy_out,
  output logic        mem_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  rw_q, rw_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic                  hit;
  logic                  accept;
  logic                  commit;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  c_rw;
  logic                  c_err;
  logic [31:0]           c_wdata;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[1:0];

  assign hit      = (mem_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
  assign addr_idx = mem_addr[DEPTH_LOG2+1:2];

`ifdef SIMPLE_MEM_RESPONDER_DECERR_EN
  assign accept = mem_req & mem_en;
`else
  assign accept = mem_req & mem_en & hit;
`endif

  // With LATENCY=1 the accept edge is also the RESP entry edge, so the commit
  // takes its operands straight from the bus instead of the latched copies.
  assign c_idx   = (state_q == ST_IDLE) ? addr_idx    : idx_q;
  assign c_rw    = (state_q == ST_IDLE) ? mem_rd_wr   : rw_q;
  assign c_wdata = (state_q == ST_IDLE) ? mem_wr_data : wdata_q;
`ifdef SIMPLE_MEM_RESPONDER_DECERR_EN
  assign c_err   = (state_q == ST_IDLE) ? ~hit        : err_q;
`else
  assign c_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d   = addr_idx;
          rw_d    = mem_rd_wr;
          wdata_d = mem_wr_data;
          err_d   = c_err;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!mem_req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        // Terminal count: this edge takes the counter to zero, so the
        // response becomes visible exactly LATENCY cycles after accept.
        end else if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: begin
        if (!mem_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (commit) begin
      if (c_err)     data_d = DECERR_DATA;
      else if (c_rw) data_d = 32'd0;
      else           data_d = mem_q[c_idx];
    end
  end

  // Writes land only on RESP entry, so aborts and resets drop them.
  assign mem_we = commit & c_rw & ~c_err & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[c_idx] <= c_wdata;
  end

  assign mem_data_valid = (state_q == ST_RESP) & mem_req;
  assign mem_data_oe    = mem_data_valid;
  assign mem_data       = mem_data_valid ? data_q : 32'd0;
  assign bus_busy_out   = (state_q != ST_IDLE);
`ifdef SIMPLE_MEM_RESPONDER_DECERR_EN
  assign mem_err        = mem_data_valid & err_q;
`else
  assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_simple_mem_responder.sv
module tb_simple_mem_responder;

  localparam int LAT = 2;
  localparam int DL2 = 8;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_en;
  logic        mem_rd_wr;
  logic [31:0] mem_wr_data;
  logic        mem_data_valid;
  logic [31:0] mem_data;
  logic        mem_data_oe;
  logic        bus_busy_out;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference memory: only words the bench has written are checked
  logic [31:0] ref_mem [1 << DL2];
  bit          known   [1 << DL2];

  simple_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_wr_data(mem_wr_data),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .mem_data_oe(mem_data_oe), .bus_busy_out(bus_busy_out), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one complete transaction and reports what was observed.
  // lat counts cycles from accept edge until valid is first seen (-1 = timeout).
  task automatic access(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                        input int stall, output int lat, output logic [31:0] data,
                        output logic err, output int unstable, output logic fell_late,
                        output logic busy_after);
    mem_addr = addr; mem_rd_wr = rw; mem_wr_data = wd; mem_req = 1'b1; mem_en = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (mem_data_valid) begin lat = n + 1; break; end
      @(posedge clk); #1;
    end
    data = mem_data; err = mem_err; unstable = 0;
    if (lat > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (mem_data_valid !== 1'b1 || mem_data_oe !== 1'b1 || mem_data !== data) unstable++;
      end
    end
    mem_req = 1'b0; mem_en = 1'b0; mem_addr = $urandom;
    #1 fell_late = mem_data_valid;
    @(posedge clk); #1;
    busy_after = bus_busy_out;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_req = 1'b0; mem_en = 1'b0; mem_rd_wr = 1'b0;
    mem_addr = 32'd0; mem_wr_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({mem_data_valid, mem_data_oe, bus_busy_out, mem_err} !== 4'b0 || mem_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: valid=%b oe=%b busy=%b err=%b data=%h, required all 0",
                 i, mem_data_valid, mem_data_oe, bus_busy_out, mem_err, mem_data);
      end
    end
  endtask

  task automatic test_write_read;
    int lat, unst; logic [31:0] d; logic e, fl, ba;
    access(32'h10, 1'b1, 32'h1234_5678, 0, lat, d, e, unst, fl, ba);
    ref_mem[4] = 32'h1234_5678; known[4] = 1;
    n_checks++;
    if (lat !== LAT || d !== 32'd0) begin
      n_fail++; $display("FAIL wr_ack: lat=%0d data=%h, required lat=%0d data=0", lat, d, LAT);
    end
    access(32'h10, 1'b0, 32'h0, 0, lat, d, e, unst, fl, ba);
    n_checks++;
    if (lat !== LAT || d !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_data: lat=%0d data=%h, required lat=%0d data=12345678", lat, d, LAT);
    end
    n_checks++;
    if (e !== 1'b0 || ba !== 1'b0) begin
      n_fail++; $display("FAIL rd_err_busy: err=%b busy_after=%b, required 0 0", e, ba);
    end
  endtask

  task automatic test_stall;
    int lat, unst; logic [31:0] d; logic e, fl, ba;
    access(32'h10, 1'b0, 32'h0, 4, lat, d, e, unst, fl, ba);
    n_checks++;
    if (lat !== LAT || d !== 32'h1234_5678 || unst !== 0) begin
      n_fail++; $display("FAIL stall_hold: lat=%0d data=%h unstable=%0d, required %0d 12345678 0", lat, d, unst, LAT);
    end
    n_checks++;
    if (fl !== 1'b0 || ba !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: valid_after_drop=%b busy_after=%b, required 0 0", fl, ba);
    end
  endtask

  task automatic test_abort;
    int lat, unst; logic [31:0] d; logic e, fl, ba;
    access(32'h20, 1'b1, 32'h5555_0001, 0, lat, d, e, unst, fl, ba);
    ref_mem[8] = 32'h5555_0001; known[8] = 1;
    mem_addr = 32'h20; mem_rd_wr = 1'b1; mem_wr_data = 32'hAAAA_AAAA; mem_req = 1'b1; mem_en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_busy_out !== 1'b1 || mem_data_valid !== 1'b0 || mem_data !== 32'd0) begin
      n_fail++; $display("FAIL abort_wait: busy=%b valid=%b data=%h, required 1 0 0", bus_busy_out, mem_data_valid, mem_data);
    end
    mem_req = 1'b0; mem_en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus_busy_out !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b, required 0", bus_busy_out);
    end
    access(32'h20, 1'b0, 32'h0, 0, lat, d, e, unst, fl, ba);
    n_checks++;
    if (lat !== LAT || d !== 32'h5555_0001) begin
      n_fail++; $display("FAIL abort_nowrite: lat=%0d data=%h, required %0d 55550001", lat, d, LAT);
    end
  endtask

  task automatic test_reset_resp;
    int lat, unst; logic [31:0] d; logic e, fl, ba; bit seen;
    access(32'h14, 1'b1, 32'hC0FF_EE05, 0, lat, d, e, unst, fl, ba);
    ref_mem[5] = 32'hC0FF_EE05; known[5] = 1;
    mem_addr = 32'h14; mem_rd_wr = 1'b0; mem_req = 1'b1; mem_en = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (mem_data_valid) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_resp_reach: valid=0, required 1 within 20 cycles"); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_data_valid !== 1'b0 || bus_busy_out !== 1'b0 || mem_data !== 32'd0 || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp: valid=%b busy=%b data=%h err=%b, required 0 0 0 0",
                         mem_data_valid, bus_busy_out, mem_data, mem_err);
    end
    reset = 1'b0; mem_req = 1'b0; mem_en = 1'b0;
    @(posedge clk); #1;
    access(32'h10, 1'b0, 32'h0, 0, lat, d, e, unst, fl, ba);
    n_checks++;
    if (lat !== LAT || d !== ref_mem[4]) begin
      n_fail++; $display("FAIL rst_preserve: lat=%0d data=%h, required %0d %h", lat, d, LAT, ref_mem[4]);
    end
  endtask

  task automatic test_miss;
    int lat, unst; logic [31:0] d; logic e, fl, ba;
    for (int w = 0; w < 2; w++) begin
      access(32'h0, 1'b1, 32'h0BAD_0000, 0, lat, d, e, unst, fl, ba);
      ref_mem[0] = 32'h0BAD_0000; known[0] = 1;
`ifdef SIMPLE_MEM_RESPONDER_DECERR_EN
      access(32'h400, w[0], 32'hFFFF_FFFF, 0, lat, d, e, unst, fl, ba);
      n_checks++;
      if (lat !== LAT || d !== 32'hDEAD_BEEF || e !== 1'b1) begin
        n_fail++; $display("FAIL decerr rw=%0d: lat=%0d data=%h err=%b, required %0d deadbeef 1", w, lat, d, e, LAT);
      end
`else
      begin
        int bad;
        bad = 0;
        mem_addr = 32'h400; mem_rd_wr = w[0]; mem_wr_data = 32'hFFFF_FFFF; mem_req = 1'b1; mem_en = 1'b1;
        for (int n = 0; n < 10; n++) begin
          @(posedge clk); #1;
          if (mem_data_valid !== 1'b0 || bus_busy_out !== 1'b0 || mem_err !== 1'b0) bad++;
        end
        mem_req = 1'b0; mem_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bad !== 0) begin
          n_fail++; $display("FAIL miss_ignore rw=%0d: %0d cycles with valid/busy/err set, required 0", w, bad);
        end
      end
`endif
      access(32'h0, 1'b0, 32'h0, 0, lat, d, e, unst, fl, ba);
      n_checks++;
      if (lat !== LAT || d !== 32'h0BAD_0000 || e !== 1'b0) begin
        n_fail++; $display("FAIL miss_nowrite rw=%0d: lat=%0d data=%h err=%b, required %0d 0bad0000 0", w, lat, d, e, LAT);
      end
    end
  endtask

  task automatic test_random;
    int lat, unst, idx, stall; logic [31:0] d, a, wd; logic e, fl, ba, rw;
    for (int it = 0; it < 60; it++) begin
      idx   = $urandom_range(0, 15);
      a     = (idx << 2) | $urandom_range(0, 3);
      rw    = $urandom_range(0, 1);
      wd    = $urandom;
      stall = $urandom_range(0, 3);
      if (rw && $urandom_range(0, 3) == 0) begin
        mem_addr = a; mem_rd_wr = 1'b1; mem_wr_data = wd; mem_req = 1'b1; mem_en = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b0; mem_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus_busy_out !== 1'b0) begin
          n_fail++; $display("FAIL rnd_abort it=%0d: busy=%b, required 0", it, bus_busy_out);
        end
      end else begin
        access(a, rw, wd, stall, lat, d, e, unst, fl, ba);
        n_checks++;
        if (lat !== LAT || unst !== 0 || fl !== 1'b0 || ba !== 1'b0 || e !== 1'b0) begin
          n_fail++; $display("FAIL rnd_timing it=%0d: lat=%0d unstable=%0d late=%b busy=%b err=%b, required %0d 0 0 0 0",
                             it, lat, unst, fl, ba, e, LAT);
        end
        if (rw) begin
          n_checks++;
          if (d !== 32'd0) begin
            n_fail++; $display("FAIL rnd_wrack it=%0d: data=%h, required 0", it, d);
          end
          ref_mem[idx] = wd; known[idx] = 1;
        end else if (known[idx]) begin
          n_checks++;
          if (d !== ref_mem[idx]) begin
            n_fail++; $display("FAIL rnd_read it=%0d idx=%0d: data=%h, required %h", it, idx, d, ref_mem[idx]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << DL2); i++) known[i] = 0;
    test_reset();
    test_write_read();
    test_stall();
    test_abort();
    test_reset_resp();
    test_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
